// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, mult/div freeze,
// branch flush and EX operand forwarding. Optional stall counter: HAZ_STALL_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_md_start,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwr,
  input  logic       ex_mem2reg,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwr,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned MDW = $clog2(MD_LAT + 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [MDW-1:0] md_cnt_q, md_cnt_d;

  logic load_use;
  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c;

  assign load_use = ex_mem2reg && ex_regwr && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
        end else if (id_md_start) begin
          state_d  = MD_BUSY;
          md_cnt_d = MDW'(MD_LAT);
        end
      end
      MD_BUSY: begin
        // Branches cannot legally resolve here, so ex_branch_taken is ignored.
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
        md_cnt_d     = md_cnt_q - MDW'(1);
        if (md_cnt_q <= MDW'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_wr,
                                         input logic [4:0] w_rd, input logic w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wr && (m_rd != 5'd0) && (m_rd == src)) begin
      sel = 2'b01;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // All outputs are held inactive while reset is asserted.
  assign pc_en      = rst && pc_en_c;
  assign ifid_en    = rst && ifid_en_c;
  assign ifid_flush = rst && ifid_flush_c;
  assign idex_flush = rst && idex_flush_c;
  assign md_busy    = rst && (state_q == MD_BUSY);
  assign fwd_a      = rst ? fwd_sel(ex_rs, mem_rd, mem_regwr, wb_rd, wb_regwr) : 2'b00;
  assign fwd_b      = rst ? fwd_sel(ex_rt, mem_rd, mem_regwr, wb_rd, wb_regwr) : 2'b00;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // CNT_W only sizes the optional stall counter.
  if (CNT_W == 0) begin : g_no_stall_cnt
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, id_md_start;
  logic       ex_regwr, ex_mem2reg, ex_branch_taken, mem_regwr, wb_regwr;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, md_busy;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_start(id_md_start),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
    .ex_mem2reg(ex_mem2reg), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy)
`ifdef HAZ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: remaining mult/div stall cycles and saturating stall count.
  int          busy_left = 0;
  longint      sc_ref    = 0;
  longint      sc_max    = (64'd1 << CNT_W) - 1;

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt, md;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_regwr, m2r, br;
    logic [4:0] mem_rd;
    logic       mem_wr;
    logic [4:0] wb_rd;
    logic       wb_wr;
    logic [3:0] ctl;   // {pc_en, ifid_en, ifid_flush, idex_flush}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_lu();
    return ex_mem2reg && ex_regwr && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (!rst) return 2'b00;
    if (mem_regwr && mem_rd != 0 && mem_rd == src) return 2'b01;
    if (wb_regwr && wb_rd != 0 && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_flush, md_busy}
  function automatic logic [4:0] ref_ctl();
    if (!rst)               return 5'b0000_0;
    if (busy_left > 0)      return 5'b0001_1;
    if (ex_branch_taken)    return 5'b1111_0;
    if (ref_lu())           return 5'b0001_0;
    return 5'b1100_0;
  endfunction

  task automatic check_model(input string tag);
    logic [4:0] c;
    c = ref_ctl();
    chk({tag, ".ctl"}, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, c[4:1]});
    chk({tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, c[0]});
    chk({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, ref_fwd(ex_rs)});
    chk({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, ref_fwd(ex_rt)});
`ifdef HAZ_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(sc_ref));
`endif
  endtask

  task automatic tick();
    logic [4:0] c;
    logic       start;
    c     = ref_ctl();
    start = !ex_branch_taken && !ref_lu() && id_md_start;
    @(posedge clk);
    if (!rst) begin
      busy_left = 0;
      sc_ref    = 0;
    end else begin
      if (!c[4] && sc_ref < sc_max) sc_ref++;
      if (busy_left > 0) busy_left--;
      else if (start) busy_left = MD_LAT;
    end
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_md_start = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwr = 0; ex_mem2reg = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_regwr = 0; wb_rd = 0; wb_regwr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sc_base;

    // Reset: outputs forced inactive even with hazard/forwarding inputs present.
    rst = 1'b0;
    clear_inputs();
    ex_branch_taken = 1; mem_rd = 3; mem_regwr = 1; ex_rs = 3; ex_rt = 3;
    @(negedge clk);
    chk("reset.ctl", {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, 32'd0);
    chk("reset.md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset.fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
`ifdef HAZ_STALL_CNT_EN
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    tick(); tick();
    rst = 1'b1;
    clear_inputs();

    //          id_rs id_rt urs urt md ex_rs ex_rt ex_rd rw m2r br mrd mw wrd ww ctl     fa     fb
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{8, 0, 1, 0, 0,  0, 0, 8,  1, 1, 0,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00});
    vecs.push_back('{0, 5, 0, 1, 0,  0, 0, 5,  1, 1, 0,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00});
    vecs.push_back('{8, 0, 0, 0, 0,  0, 0, 8,  1, 1, 0,  0, 0, 0, 0, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{0, 0, 1, 1, 0,  0, 0, 0,  1, 1, 0,  0, 0, 0, 0, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{8, 0, 1, 0, 0,  0, 0, 8,  0, 1, 0,  0, 0, 0, 0, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{8, 0, 1, 0, 0,  0, 0, 8,  1, 0, 0,  0, 0, 0, 0, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{8, 0, 1, 0, 1,  0, 0, 8,  1, 1, 1,  0, 0, 0, 0, 4'b1111, 2'b00, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 9, 0,  0, 0, 0,  9, 1, 9, 1, 4'b1100, 2'b00, 2'b01});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 9, 0,  0, 0, 0,  9, 0, 9, 1, 4'b1100, 2'b00, 2'b10});
    vecs.push_back('{6, 0, 1, 0, 1,  0, 0, 6,  1, 1, 0,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 1, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{0, 0, 0, 0, 0,  3, 4, 0,  0, 0, 0,  3, 1, 4, 1, 4'b1100, 2'b01, 2'b10});
    vecs.push_back('{0, 0, 0, 0, 0,  7, 7, 0,  0, 0, 0,  7, 1, 7, 1, 4'b1100, 2'b01, 2'b01});

    foreach (vecs[i]) begin
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt; id_md_start = vecs[i].md;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_rd = vecs[i].ex_rd;
      ex_regwr = vecs[i].ex_regwr; ex_mem2reg = vecs[i].m2r; ex_branch_taken = vecs[i].br;
      mem_rd = vecs[i].mem_rd; mem_regwr = vecs[i].mem_wr;
      wb_rd = vecs[i].wb_rd; wb_regwr = vecs[i].wb_wr;
      @(negedge clk);
      chk($sformatf("vec%0d.ctl", i), {28'd0, pc_en, ifid_en, ifid_flush, idex_flush},
          {28'd0, vecs[i].ctl});
      chk($sformatf("vec%0d.md_busy", i), {31'd0, md_busy}, 32'd0);
      chk($sformatf("vec%0d.fwd", i), {28'd0, fwd_a, fwd_b}, {28'd0, vecs[i].fa, vecs[i].fb});
      tick();
    end

    // Load-use: one stall cycle, then the load result is forwarded from MEM, then WB.
    clear_inputs();
    ex_mem2reg = 1; ex_regwr = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    @(negedge clk);
    chk("lu.stall", {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, 32'b0001);
    tick();
    clear_inputs();
    ex_rs = 8; mem_rd = 8; mem_regwr = 1;
    @(negedge clk);
    chk("lu.run", {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, 32'b1100);
    chk("lu.fwd_mem", {30'd0, fwd_a}, 32'b01);
    tick();
    clear_inputs();
    ex_rs = 8; wb_rd = 8; wb_regwr = 1;
    @(negedge clk);
    chk("lu.fwd_wb", {30'd0, fwd_a}, 32'b10);
    tick();

    // Mult/div: unstalled issue, MD_LAT busy cycles (branch ignored), then RUN.
    clear_inputs();
    sc_base = sc_ref;
    id_md_start = 1;
    @(negedge clk);
    chk("md.issue", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, md_busy}, 32'b1100_0);
    tick();
    id_md_start = 0;
    for (int unsigned k = 0; k < MD_LAT; k++) begin
      ex_branch_taken = (k == 1);
      @(negedge clk);
      chk($sformatf("md.busy%0d", k),
          {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, md_busy}, 32'b0001_1);
      tick();
    end
    ex_branch_taken = 0;
    @(negedge clk);
    chk("md.done", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, md_busy}, 32'b1100_0);
`ifdef HAZ_STALL_CNT_EN
    chk("md.stall_cnt", 32'(stall_cnt), 32'(sc_base + MD_LAT));
`endif
    tick();

    // Reset asserted on the 2nd busy cycle: immediate forced outputs, RUN afterwards.
    id_md_start = 1;
    @(negedge clk);
    tick();
    id_md_start = 0;
    @(negedge clk);
    chk("rstmid.busy1", {31'd0, md_busy}, 32'd1);
    tick();
    mem_rd = 6; mem_regwr = 1; ex_rs = 6;
    #2 rst = 1'b0;
    #1;
    chk("rstmid.ctl", {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, 32'd0);
    chk("rstmid.md_busy", {31'd0, md_busy}, 32'd0);
    chk("rstmid.fwd_a", {30'd0, fwd_a}, 32'd0);
    tick();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    chk("rstmid.after", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, md_busy}, 32'b1100_0);
`ifdef HAZ_STALL_CNT_EN
    chk("rstmid.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    tick();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      id_md_start = ($urandom_range(0, 7) == 0);
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_regwr = 1'($urandom); ex_mem2reg = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_rd = 5'($urandom_range(0, 3)); mem_regwr = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_regwr = 1'($urandom);
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller for the 5-stage MIPS pipeline. It sequences the IF/ID and ID/EX pipeline registers and the PC: it detects load-use hazards, freezes the front end while the multi-cycle multiply/divide unit is busy, and flushes on taken branches. It also produces the EX-stage operand forwarding selects. It sits beside the ID/EX register and drives its flush input, plus the PC and IF/ID enables.

## Interface
Parameters:
- MD_LAT, 4: busy cycles of the mult/div unit after issue; legal range 1..255.
- CNT_W, 16: width of the stall counter (only used when HAZ_STALL_CNT_EN is defined).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
- id_md_start  in  1  ID holds a mult/div instruction.
- ex_rs, ex_rt  in  5 each  source registers held in ID/EX.
- ex_rd  in  5  destination held in ID/EX.
- ex_regwr, ex_mem2reg  in  1 each  ID/EX write-back enable / load flag.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_rd, mem_regwr  in  5, 1  EX/MEM destination and write enable.
- wb_rd, wb_regwr  in  5, 1  MEM/WB destination and write enable.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_flush  out  1  load a bubble (all-zero controls) into ID/EX on the next edge.
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
- md_busy  out  1  FSM is in MD_BUSY.
- stall_cnt  out  CNT_W  stall-cycle counter; present only with HAZ_STALL_CNT_EN.

## Operation
- FSM states: RUN (0), MD_BUSY (1). Down-counter md_cnt has width ceil(log2(MD_LAT+1)).
- In RUN the events are resolved in priority order:
  1. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. If id_md_start is asserted in the same cycle, it is discarded and the FSM stays in RUN.
  2. Load-use: ex_mem2reg & ex_regwr & ex_rd≠0, and (id_use_rs & id_rs==ex_rd, or id_use_rt & id_rt==ex_rd). Response: pc_en=0, ifid_en=0, idex_flush=1. A pending id_md_start is re-evaluated next cycle.
  3. id_md_start: no stall this cycle, so the mult/div instruction advances into EX. Next state is MD_BUSY with md_cnt←MD_LAT.
  4. Otherwise: pc_en=1, ifid_en=1, both flushes 0.
- In MD_BUSY: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0. md_cnt decrements each cycle; when md_cnt==1, next state is RUN. ex_branch_taken is a protocol violation in this state and is ignored.
- Forwarding is combinational and computed per operand (shown for fwd_a with ex_rs; fwd_b uses ex_rt the same way):
  - 01 if mem_regwr & mem_rd≠0 & mem_rd==ex_rs.
  - Otherwise 10 if wb_regwr & wb_rd≠0 & wb_rd==ex_rs.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.

## Timing
- Reset (rst low, asynchronous): state=RUN, md_cnt=0, stall_cnt=0. While rst is low, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=0, fwd_a=fwd_b=00, md_busy=0.
- After reset release: first rising edge operates in RUN.
- pc_en, ifid_en, ifid_flush and idex_flush are combinational from state and inputs, and take effect at the next rising edge.
- Load-use stall: exactly 1 cycle. On the following cycle the load has moved to MEM, and the operand is forwarded via fwd=01... then 10 as it retires.
- Mult/div: the issue cycle is unstalled, followed by exactly MD_LAT stall cycles; md_busy is high for those MD_LAT cycles. MD_LAT=1 gives a single busy cycle.
- Reset asserted during MD_BUSY: the FSM returns to RUN immediately and the remaining count is lost.
- Forwarding outputs are valid within the same cycle as their inputs; no latency.

## Configuration
- HAZ_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - Increments by 1 on every rising edge where rst is high and pc_en==0.
  - Saturates at 2^CNT_W−1.
  - Reset value 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Load-use: lw $t0 in EX (ex_mem2reg=1, ex_regwr=1, ex_rd=8), ID has id_rs=8 with id_use_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then the next cycle runs with fwd_a=01 (mem_rd=8).
- Zero register: ex_rd=0 load with id_rs=0 -> no stall. mem_rd=0 with ex_rs=0 -> fwd_a=00.
- Mult/div with MD_LAT=4: id_md_start=1 in RUN -> issue cycle with pc_en=1, then exactly 4 cycles of md_busy=1, pc_en=0, idex_flush=1, then RUN. With HAZ_STALL_CNT_EN, stall_cnt=4.
- Simultaneous events: ex_branch_taken=1 with id_md_start=1 and a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1, and the FSM stays in RUN.
- Forwarding priority: mem_rd=wb_rd=ex_rt=9 with both write enables high -> fwd_b=01. Drop mem_regwr -> fwd_b=10.
- Reset mid-busy: assert rst low on the 2nd MD_BUSY cycle -> outputs immediately take the reset values listed under Timing. After release the block is in RUN with md_busy=0.
